// File: rtl/pulse_conv_pkg.sv
// Shared constants for the pulse-to-level converters: FSM state codes and MODE
// names. Each MODE string is zero-padded on the left to MODE_W bits so that values compare equal.
package pulse_conv_pkg;

    localparam int MODE_W = 72;

    localparam logic [MODE_W-1:0] MODE_STRETCH   = {16'h0, "stretch"};
    localparam logic [MODE_W-1:0] MODE_TOGGLE    = {24'h0, "toggle"};
    localparam logic [MODE_W-1:0] MODE_HANDSHAKE = "handshake";

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_HOLD         = 2'd1;
    localparam logic [1:0] ST_REQ          = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK_LOW = 2'd3;

    localparam logic [1:0] MID_NONE      = 2'd0;
    localparam logic [1:0] MID_STRETCH   = 2'd1;
    localparam logic [1:0] MID_TOGGLE    = 2'd2;
    localparam logic [1:0] MID_HANDSHAKE = 2'd3;

    function automatic logic [1:0] mode_id(input logic [MODE_W-1:0] m);
        if (m == MODE_STRETCH)   return MID_STRETCH;
        if (m == MODE_TOGGLE)    return MID_TOGGLE;
        if (m == MODE_HANDSHAKE) return MID_HANDSHAKE;
        return MID_NONE;
    endfunction

endpackage

// File: rtl/pulse2level_hold_cnt.sv
// Down-counter with a synchronous load and decrement, plus a zero flag.
module pulse2level_hold_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse2level.sv
// Converts single-cycle event pulses into a level: stretched, toggled, or held
// until a req/ack handshake completes. All outputs come directly from registers.
module pulse2level
    import pulse_conv_pkg::*;
#(
    parameter logic [MODE_W-1:0] MODE                  = MODE_STRETCH,
    parameter int                HOLD_CYCLES           = 4,
    parameter int                RETRIGGER             = 1,
    parameter int                PULSE_ACTIVE_POLARITY = 1,
    parameter int                LEVEL_ACTIVE_POLARITY = 1,
    parameter int                SYNC                  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    input  logic ack_in,
    output logic level_out,
    output logic busy,
    output logic missed
);

    localparam logic [1:0] MID    = mode_id(MODE);
    localparam int         CW     = $clog2(HOLD_CYCLES + 1);
    localparam logic       LVL_ON = (LEVEL_ACTIVE_POLARITY != 0);
    localparam logic       RETRIG = (RETRIGGER != 0);

    logic p_raw, p;
    assign p_raw = (PULSE_ACTIVE_POLARITY != 0) ? pulse_in : ~pulse_in;

    generate
        if (SYNC > 0) begin : g_sync
            logic p_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) p_q <= 1'b0;
                else      p_q <= p_raw;
            end
            assign p = p_q;
        end else begin : g_nosync
            assign p = p_raw;
        end
    endgenerate

    logic [1:0]    state_q, state_d;
    logic          pend_q, pend_d;
    logic          miss_q, miss_d;
    logic          level_q, level_d;
    logic          act_q, act_d;
    logic          cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0] cnt;

    assign act_q = (level_q == LVL_ON);

    pulse2level_hold_cnt #(.W(CW)) u_hold_cnt (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (cnt_load),
        .load_val_i (CW'(HOLD_CYCLES - 1)),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        miss_d   = 1'b0;
        act_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (MID)
            MID_STRETCH: begin
                case (state_q)
                    ST_IDLE: if (p) begin
                        state_d  = ST_HOLD;
                        cnt_load = 1'b1;
                    end
                    ST_HOLD: begin
                        if (p && RETRIG) begin
                            cnt_load = 1'b1;
                        end else begin
                            miss_d = p;
                            if (cnt_zero) state_d = ST_IDLE;
                            else          cnt_dec = 1'b1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
                act_d = (state_d == ST_HOLD);
            end
            MID_TOGGLE: begin
                state_d = ST_IDLE;
                act_d   = p ? ~act_q : act_q;
            end
            MID_HANDSHAKE: begin
                // A pulse in the same cycle that WAIT_ACK_LOW exits is queued first, so it can start the next REQ directly.
                if (state_q != ST_IDLE && p) begin
                    if (RETRIG && !pend_q) pend_d = 1'b1;
                    else                   miss_d = 1'b1;
                end
                case (state_q)
                    ST_IDLE: if (p) state_d = ST_REQ;
                    ST_REQ:  if (ack_in) state_d = ST_WAIT_ACK_LOW;
                    ST_WAIT_ACK_LOW: if (!ack_in) begin
                        if (pend_d) begin
                            state_d = ST_REQ;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
                act_d = (state_d == ST_REQ);
            end
            default: state_d = ST_IDLE;
        endcase
        level_d = act_d ? LVL_ON : ~LVL_ON;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            miss_q  <= 1'b0;
            level_q <= ~LVL_ON;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            miss_q  <= miss_d;
            level_q <= level_d;
        end
    end

    assign level_out = level_q;
    assign busy      = (state_q != ST_IDLE);
    assign missed    = miss_q;

endmodule

// File: tb/tb_pulse2level.sv
// Self-checking bench for pulse2level: several parameterisations share one pulse/ack
// stream; expectations come from pulse-history arithmetic and an event-level handshake model.
module tb_pulse2level;
    import pulse_conv_pkg::*;

    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pulse = 1'b0;
    logic ack = 1'b0;
    logic pulse_n;
    assign pulse_n = ~pulse;

    always #5 clk = ~clk;

    logic l_a, b_a, m_a;   // stretch H=4 retrigger
    logic l_b, b_b, m_b;   // stretch H=4 no retrigger
    logic l_c, b_c, m_c;   // stretch H=1 no retrigger
    logic l_t, b_t, m_t;   // toggle
    logic l_h, b_h, m_h;   // handshake retrigger
    logic l_p, b_p, m_p;   // stretch H=4, both polarities low
    logic l_x, b_x, m_x;   // unknown mode

    pulse2level #(.MODE(MODE_STRETCH), .HOLD_CYCLES(4), .RETRIGGER(1)) u_a (
        .clk(clk), .rst(rst), .pulse_in(pulse), .ack_in(ack), .level_out(l_a), .busy(b_a), .missed(m_a));
    pulse2level #(.MODE(MODE_STRETCH), .HOLD_CYCLES(4), .RETRIGGER(0)) u_b (
        .clk(clk), .rst(rst), .pulse_in(pulse), .ack_in(ack), .level_out(l_b), .busy(b_b), .missed(m_b));
    pulse2level #(.MODE(MODE_STRETCH), .HOLD_CYCLES(1), .RETRIGGER(0)) u_c (
        .clk(clk), .rst(rst), .pulse_in(pulse), .ack_in(ack), .level_out(l_c), .busy(b_c), .missed(m_c));
    pulse2level #(.MODE(MODE_TOGGLE)) u_t (
        .clk(clk), .rst(rst), .pulse_in(pulse), .ack_in(ack), .level_out(l_t), .busy(b_t), .missed(m_t));
    pulse2level #(.MODE(MODE_HANDSHAKE), .RETRIGGER(1)) u_h (
        .clk(clk), .rst(rst), .pulse_in(pulse), .ack_in(ack), .level_out(l_h), .busy(b_h), .missed(m_h));
    pulse2level #(.MODE(MODE_STRETCH), .HOLD_CYCLES(4), .RETRIGGER(1),
                  .PULSE_ACTIVE_POLARITY(0), .LEVEL_ACTIVE_POLARITY(0)) u_p (
        .clk(clk), .rst(rst), .pulse_in(pulse_n), .ack_in(ack), .level_out(l_p), .busy(b_p), .missed(m_p));
    pulse2level #(.MODE({32'h0, "bogus"})) u_x (
        .clk(clk), .rst(rst), .pulse_in(pulse), .ack_in(ack), .level_out(l_x), .busy(b_x), .missed(m_x));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // pulse/ack history per cycle since reset release; acc[k] marks pulses a
    // non-retriggering stretcher accepts (k=0: H=4, k=1: H=1)
    bit ph [0:MAXC-1];
    bit ah [0:MAXC-1];
    bit acc [0:1][0:MAXC-1];

    // handshake reference: request outstanding, waiting for ack release, queued event
    bit hm_req, hm_rel, hm_queued, hm_miss;

    function automatic bit hist(input int i);
        if (i < 0 || i >= MAXC) return 1'b0;
        return ph[i];
    endfunction

    function automatic bit any_ph(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) if (hist(i)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_acc(input int k, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) if (i >= 0 && i < MAXC && acc[k][i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit parity_upto(input int hi);
        bit r = 1'b0;
        for (int i = 0; i <= hi; i++) r ^= hist(i);
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < MAXC; i++) begin
            ph[i] = 1'b0; ah[i] = 1'b0; acc[0][i] = 1'b0; acc[1][i] = 1'b0;
        end
        cyc = 0;
        hm_req = 1'b0; hm_rel = 1'b0; hm_queued = 1'b0; hm_miss = 1'b0;
    endtask

    task automatic hs_event(input bit ev, input bit ak);
        hm_miss = 1'b0;
        if (!hm_req && !hm_rel) begin
            if (ev) hm_req = 1'b1;
        end else begin
            if (ev) begin
                if (hm_queued) hm_miss = 1'b1;
                else           hm_queued = 1'b1;
            end
            if (hm_req) begin
                if (ak) begin hm_req = 1'b0; hm_rel = 1'b1; end
            end else if (!ak) begin
                hm_rel = 1'b0;
                if (hm_queued) begin hm_queued = 1'b0; hm_req = 1'b1; end
            end
        end
    endtask

    // Advance one cycle: the edge consumes last cycle's inputs, then new inputs
    // are driven and the task returns at the following falling edge.
    task automatic step(input bit pl, input bit ak);
        @(posedge clk);
        hs_event((cyc >= 1) ? ph[cyc-1] : 1'b0, ah[cyc]);
        cyc++;
        #1;
        pulse = pl;
        ack   = ak;
        ph[cyc] = pl;
        ah[cyc] = ak;
        acc[0][cyc] = pl && !any_acc(0, cyc-4, cyc-1);
        acc[1][cyc] = pl && !any_acc(1, cyc-1, cyc-1);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0; pulse = 1'b0; ack = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        vectors++; if (l_a !== 1'b0) begin miscompares++; $display("FAIL reset_level_hi got %b want 0", l_a); end
        vectors++; if (l_p !== 1'b1) begin miscompares++; $display("FAIL reset_level_lo got %b want 1", l_p); end
        vectors++; if ({l_b, l_c, l_t, l_h, l_x} !== 5'b0) begin miscompares++; $display("FAIL reset_levels got %b want 00000", {l_b, l_c, l_t, l_h, l_x}); end
        vectors++; if ({b_a, b_b, b_c, b_t, b_h, b_p, b_x} !== 7'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0000000", {b_a, b_b, b_c, b_t, b_h, b_p, b_x}); end
        vectors++; if ({m_a, m_b, m_c, m_t, m_h, m_p, m_x} !== 7'b0) begin miscompares++; $display("FAIL reset_missed got %b want 0000000", {m_a, m_b, m_c, m_t, m_h, m_p, m_x}); end
        apply_reset();
    endtask

    task automatic test_stretch_single();
        bit e;
        apply_reset();
        for (int c = 1; c <= 22; c++) begin
            step(c == 10, 1'b0);
            e = (c >= 12 && c <= 15);
            vectors++; if (l_a !== e) begin miscompares++; $display("FAIL single_level c=%0d got %b want %b", c, l_a, e); end
            vectors++; if (b_a !== e) begin miscompares++; $display("FAIL single_busy c=%0d got %b want %b", c, b_a, e); end
            vectors++; if (m_a !== 1'b0) begin miscompares++; $display("FAIL single_missed c=%0d got %b want 0", c, m_a); end
            vectors++; if (l_p !== !e) begin miscompares++; $display("FAIL pol_level c=%0d got %b want %b", c, l_p, !e); end
            vectors++; if (l_c !== (c == 12)) begin miscompares++; $display("FAIL h1_level c=%0d got %b want %b", c, l_c, (c == 12)); end
        end
    endtask

    task automatic test_stretch_retrigger(input int second);
        bit e1, e0, em;
        apply_reset();
        for (int c = 1; c <= 24; c++) begin
            step(c == 10 || c == second, 1'b0);
            e1 = (c >= 12 && c <= second + 5);
            e0 = (c >= 12 && c <= 15);
            em = (c == second + 2);
            vectors++; if (l_a !== e1) begin miscompares++; $display("FAIL retrig1_level p2=%0d c=%0d got %b want %b", second, c, l_a, e1); end
            vectors++; if (l_b !== e0) begin miscompares++; $display("FAIL retrig0_level p2=%0d c=%0d got %b want %b", second, c, l_b, e0); end
            vectors++; if (m_b !== em) begin miscompares++; $display("FAIL retrig0_missed p2=%0d c=%0d got %b want %b", second, c, m_b, em); end
        end
    endtask

    task automatic test_toggle();
        bit e;
        apply_reset();
        for (int c = 1; c <= 16; c++) begin
            step(c == 5 || c == 8 || c == 9, 1'b0);
            e = (c >= 7 && c <= 9) || (c >= 11);
            vectors++; if (l_t !== e) begin miscompares++; $display("FAIL toggle_level c=%0d got %b want %b", c, l_t, e); end
            vectors++; if ({b_t, m_t} !== 2'b00) begin miscompares++; $display("FAIL toggle_flags c=%0d got %b want 00", c, {b_t, m_t}); end
        end
    endtask

    task automatic test_handshake();
        bit el, eb, em;
        apply_reset();
        for (int c = 1; c <= 24; c++) begin
            step(c == 2 || c == 5 || c == 7 || c == 19,
                 c == 9 || c == 10 || c == 14 || c == 15 || c == 20 || c == 21);
            el = (c >= 4 && c <= 9) || (c >= 12 && c <= 14) || (c == 21);
            eb = (c >= 4 && c <= 16) || (c == 21) || (c == 22);
            em = (c == 9);
            vectors++; if (l_h !== el) begin miscompares++; $display("FAIL hs_level c=%0d got %b want %b", c, l_h, el); end
            vectors++; if (b_h !== eb) begin miscompares++; $display("FAIL hs_busy c=%0d got %b want %b", c, b_h, eb); end
            vectors++; if (m_h !== em) begin miscompares++; $display("FAIL hs_missed c=%0d got %b want %b", c, m_h, em); end
        end
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        for (int c = 1; c <= 13; c++) step(c == 10, 1'b0);
        vectors++; if (l_a !== 1'b1) begin miscompares++; $display("FAIL midrst_pre got %b want 1", l_a); end
        #1 rst = 1'b0;
        #1;
        vectors++; if ({l_a, b_a} !== 2'b00) begin miscompares++; $display("FAIL midrst_async got %b want 00", {l_a, b_a}); end
        vectors++; if ({l_p, b_p} !== 2'b10) begin miscompares++; $display("FAIL midrst_async_pol got %b want 10", {l_p, b_p}); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        for (int c = 1; c <= 10; c++) begin
            step(1'b0, 1'b0);
            vectors++; if ({l_a, b_a, l_p} !== 3'b001) begin miscompares++; $display("FAIL midrst_after c=%0d got %b want 001", c, {l_a, b_a, l_p}); end
        end
    endtask

    task automatic test_random();
        bit e_r1, e_r0, mm_r0, e_h1, mm_h1, e_t;
        apply_reset();
        for (int c = 1; c <= 700; c++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            e_r1  = any_ph(c - 5, c - 2);
            e_r0  = any_acc(0, c - 5, c - 2);
            mm_r0 = hist(c - 2) && !any_acc(0, c - 2, c - 2);
            e_h1  = any_acc(1, c - 2, c - 2);
            mm_h1 = hist(c - 2) && !e_h1;
            e_t   = parity_upto(c - 2);
            vectors++; if ({l_a, b_a, m_a} !== {e_r1, e_r1, 1'b0}) begin miscompares++; $display("FAIL rnd_r1 c=%0d got %b want %b", c, {l_a, b_a, m_a}, {e_r1, e_r1, 1'b0}); end
            vectors++; if ({l_b, b_b, m_b} !== {e_r0, e_r0, mm_r0}) begin miscompares++; $display("FAIL rnd_r0 c=%0d got %b want %b", c, {l_b, b_b, m_b}, {e_r0, e_r0, mm_r0}); end
            vectors++; if ({l_c, b_c, m_c} !== {e_h1, e_h1, mm_h1}) begin miscompares++; $display("FAIL rnd_h1 c=%0d got %b want %b", c, {l_c, b_c, m_c}, {e_h1, e_h1, mm_h1}); end
            vectors++; if ({l_t, b_t, m_t} !== {e_t, 2'b00}) begin miscompares++; $display("FAIL rnd_tog c=%0d got %b want %b", c, {l_t, b_t, m_t}, {e_t, 2'b00}); end
            vectors++; if ({l_h, b_h, m_h} !== {hm_req, hm_req | hm_rel, hm_miss}) begin miscompares++; $display("FAIL rnd_hs c=%0d got %b want %b", c, {l_h, b_h, m_h}, {hm_req, hm_req | hm_rel, hm_miss}); end
            vectors++; if ({l_p, b_p, m_p} !== {!e_r1, e_r1, 1'b0}) begin miscompares++; $display("FAIL rnd_pol c=%0d got %b want %b", c, {l_p, b_p, m_p}, {!e_r1, e_r1, 1'b0}); end
            vectors++; if ({l_x, b_x, m_x} !== 3'b000) begin miscompares++; $display("FAIL rnd_badmode c=%0d got %b want 000", c, {l_x, b_x, m_x}); end
        end
    endtask

    initial begin
        test_reset();
        test_stretch_single();
        test_stretch_retrigger(13);
        test_stretch_retrigger(14);
        test_toggle();
        test_handshake();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pulse2level.md
PULSE2LEVEL -- requirements
Module: pulse2level

Interface
REQ-001 Parameter MODE, default "stretch", selects the conversion type: "stretch", "toggle" or "handshake".
REQ-002 Parameter HOLD_CYCLES, default 4 (integer >=1), sets the number of cycles level_out stays active in stretch mode.
REQ-003 Parameter RETRIGGER, default 1; 1 means pulses arriving while busy are accepted, 0 means they are dropped.
REQ-004 Parameter PULSE_ACTIVE_POLARITY, default 1; 1 means pulse_in is active high, 0 means active low.
REQ-005 Parameter LEVEL_ACTIVE_POLARITY, default 1; 1 means level_out is active high, 0 means active low.
REQ-006 Parameter SYNC, default 1; when >0, pulse_in is registered before use, adding 1 clk of latency.
REQ-007 Port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-008 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-009 Port pulse_in, input, 1 bit: event pulse, normally one cycle wide, polarity per PULSE_ACTIVE_POLARITY.
REQ-010 Port ack_in, input, 1 bit: active-high acknowledge, used only in handshake mode and ignored otherwise.
REQ-011 Port level_out, output, 1 bit: registered level output.
REQ-012 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 Port missed, output, 1 bit: one-cycle registered strobe, high when an accepted-mode pulse was dropped.

Function
REQ-014 The internal event p is pulse_in normalised to active high; when SYNC>0, p is pulse_in delayed one register.
REQ-015 The design has no combinational path from any input to any output; latency from p to level_out is 1 clk, so pulse_in to level_out is 2 clk with SYNC=1.
REQ-016 Stretch mode uses states IDLE and HOLD.
  - IDLE, p=1: go to HOLD, load the counter with HOLD_CYCLES-1, level_out goes active.
REQ-017 In HOLD, the counter decrements each cycle; at counter=0 with no accepted p, the block returns to IDLE and level_out goes inactive.
  - An isolated pulse gives exactly HOLD_CYCLES active cycles.
REQ-018 Stretch, p in HOLD:
  - RETRIGGER=1: counter reloads to HOLD_CYCLES-1, with no gap in level_out.
  - RETRIGGER=0: p is ignored and missed pulses for 1 cycle, including when p lands on the final hold cycle.
REQ-019 Toggle mode: level_out inverts on every p; busy and missed stay 0.
REQ-020 Handshake mode uses states IDLE, REQ and WAIT_ACK_LOW.
  - IDLE to REQ on p; level_out is active in REQ only.
  - REQ to WAIT_ACK_LOW on ack_in=1.
  - WAIT_ACK_LOW to IDLE on ack_in=0.
REQ-021 Handshake, p while not IDLE:
  - RETRIGGER=1 and pending flag clear: set pending.
  - Otherwise: missed pulses.
  - Leaving WAIT_ACK_LOW with pending set: go directly to REQ (clearing pending) instead of IDLE.
REQ-022 Handshake, simultaneous p and ack_in=1 in REQ: the ack transition is taken and p is handled per REQ-021.
REQ-023 ack_in=1 in IDLE is ignored; p arriving together with ack_in=1 in IDLE still enters REQ.
REQ-024 The stretch counter width is $clog2(HOLD_CYCLES+1); HOLD_CYCLES=1 yields a single-cycle level with no HOLD dwell beyond that cycle.
REQ-025 An unrecognised MODE drives level_out constant inactive and busy=missed=0.

Reset
REQ-026 Assertion of rst (low) asynchronously forces the following; the pulse is discarded even mid-operation:
  - state IDLE, counter 0, pending 0, SYNC register inactive;
  - level_out inactive per LEVEL_ACTIVE_POLARITY;
  - busy 0, missed 0.
REQ-027 The first p is recognised on the second rising edge after rst deasserts; deassertion is synchronised externally.

Structure
REQ-028 State encodings (IDLE, HOLD, REQ, WAIT_ACK_LOW) and MODE string constants live in the shared package pulse_conv_pkg.
REQ-029 The down-counter with load/decrement/zero flag is a separate sub-module, pulse2level_hold_cnt, parameterised by width.

Verification
REQ-030 Stretch, HOLD_CYCLES=4, SYNC=1: 1-cycle pulse at cycle 10 -> level_out high for cycles 12-15, busy high for the same cycles, missed never high.
REQ-031 Stretch, RETRIGGER=1: pulses at cycles 10 and 13 -> level_out high continuously for cycles 12-18; with RETRIGGER=0, level_out is high for cycles 12-15 and missed is high at cycle 15.
REQ-032 Toggle: pulses at cycles 5, 8 and 9 -> level_out high from cycle 7, low from cycle 10, high from cycle 11.
REQ-033 Handshake, RETRIGGER=1, with a second and third p while in REQ:
  - level_out drops the cycle after ack_in=1;
  - the second p is pending, and REQ is re-entered the cycle after ack_in falls;
  - the third p raises missed.
REQ-034 Stretch, rst low for 1 cycle at cycle 13 of an active hold -> level_out inactive and busy 0 immediately (asynchronously), with no resumption after release.
REQ-035 PULSE_ACTIVE_POLARITY=0 with LEVEL_ACTIVE_POLARITY=0: an active-low pulse produces an active-low stretch of HOLD_CYCLES cycles, and level_out is 1 during reset.
